// File: rtl/parser_rule_loader.sv
// Serialises one parser layer-rule descriptor into single-word rule writes, optionally reading each back to compare.
// Latency: writes at T+1..T+N after accept at T; ready only in IDLE, so a held descriptor waits until DONE passes.
module parser_rule_loader #(
  parameter int TYPE_NUM          = 4,
  parameter int KEY_FILED_NUM     = 8,
  parameter int TYPE_OFFSET_WIDTH = 6,
  parameter int KEY_OFFSET_WIDTH  = 6,
  parameter int HEAD_SHIFT_WIDTH  = 6,
  parameter int META_SHIFT_WIDTH  = 6,
  parameter int RD_TIMEOUT        = 16
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic                                       i_desc_valid,
  output logic                                       o_desc_ready,
  input  logic [7:0]                                 i_desc_layer,
  input  logic                                       i_desc_verify,
  input  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]      i_desc_type_offset,
  input  logic [KEY_FILED_NUM-1:0]                   i_desc_key_offset_v,
  input  logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0]  i_desc_key_offset,
  input  logic [HEAD_SHIFT_WIDTH-1:0]                i_desc_head_shift,
  input  logic [META_SHIFT_WIDTH-1:0]                i_desc_meta_shift,
  output logic                                       o_rule_wren,
  output logic                                       o_rule_rden,
  output logic [31:0]                                o_rule_addr,
  output logic [31:0]                                o_rule_wdata,
  input  logic                                       i_rule_rdata_valid,
  input  logic [31:0]                                i_rule_rdata,
  output logic                                       o_busy,
  output logic                                       o_done,
  output logic [1:0]                                 o_err,
  output logic [31:0]                                o_err_addr
);

  localparam int N  = TYPE_NUM + KEY_FILED_NUM + 2;
  localparam int CW = $clog2(RD_TIMEOUT) + 1;

  localparam logic [7:0]    LAST_IDX = 8'(N - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(RD_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_CMP     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Builds {addr, wdata} for word index idx of a rule; used for both writing and readback compare.
  function automatic logic [63:0] gen_word(
    input logic [7:0]                                idx,
    input logic [7:0]                                layer,
    input logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     toff,
    input logic [KEY_FILED_NUM-1:0]                  kv,
    input logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] koff,
    input logic [HEAD_SHIFT_WIDTH-1:0]               hs,
    input logic [META_SHIFT_WIDTH-1:0]               ms
  );
    int                                        i;
    logic [3:0]                                info;
    logic [7:0]                                id;
    logic [31:0]                               data;
    logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     tsh;
    logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] ksh;
    logic [KEY_FILED_NUM-1:0]                  vsh;
    i    = int'(idx);
    info = 4'd0;
    id   = 8'd0;
    data = 32'd0;
    tsh  = '0;
    ksh  = '0;
    vsh  = '0;
    if (i < TYPE_NUM) begin
      info = 4'd2;
      id   = idx;
      tsh  = toff >> (i * TYPE_OFFSET_WIDTH);
      data[TYPE_OFFSET_WIDTH-1:0] = tsh[TYPE_OFFSET_WIDTH-1:0];
    end else if (i < TYPE_NUM + KEY_FILED_NUM) begin
      info = 4'd3;
      id   = 8'(i - TYPE_NUM);
      ksh  = koff >> ((i - TYPE_NUM) * KEY_OFFSET_WIDTH);
      vsh  = kv >> (i - TYPE_NUM);
      data[16] = vsh[0];
      data[KEY_OFFSET_WIDTH-1:0] = ksh[KEY_OFFSET_WIDTH-1:0];
    end else if (i == TYPE_NUM + KEY_FILED_NUM) begin
      info = 4'd4;
      data[HEAD_SHIFT_WIDTH-1:0] = hs;
    end else begin
      info = 4'd5;
      data[META_SHIFT_WIDTH-1:0] = ms;
    end
    return {layer, info, 12'h000, id, data};
  endfunction

  logic [2:0]                                state_q, state_d;
  logic [7:0]                                idx_q, idx_d;
  logic [CW-1:0]                             tmo_q, tmo_d;
  logic                                      wren_q, wren_d;
  logic                                      rden_q, rden_d;
  logic [31:0]                               addr_q, addr_d;
  logic [31:0]                               wdata_q, wdata_d;
  logic                                      done_q, done_d;
  logic [1:0]                                err_q, err_d;
  logic [31:0]                               err_addr_q, err_addr_d;

  logic [7:0]                                layer_q;
  logic                                      verify_q;
  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     toff_q;
  logic [KEY_FILED_NUM-1:0]                  kv_q;
  logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] koff_q;
  logic [HEAD_SHIFT_WIDTH-1:0]               hs_q;
  logic [META_SHIFT_WIDTH-1:0]               ms_q;

  logic        accept;
  logic        last_word;
  logic [7:0]  nxt_idx;
  logic [63:0] in_word;
  logic [63:0] cur_word;
  logic [63:0] nxt_word;

  assign accept    = i_desc_valid && (state_q == S_IDLE);
  assign last_word = (idx_q == LAST_IDX);
  assign nxt_idx   = last_word ? 8'd0 : idx_q + 8'd1;

  // The first word comes straight from the inputs so writing starts the cycle after accept.
  assign in_word  = gen_word(8'd0, i_desc_layer, i_desc_type_offset, i_desc_key_offset_v,
                             i_desc_key_offset, i_desc_head_shift, i_desc_meta_shift);
  assign cur_word = gen_word(idx_q, layer_q, toff_q, kv_q, koff_q, hs_q, ms_q);
  assign nxt_word = gen_word(nxt_idx, layer_q, toff_q, kv_q, koff_q, hs_q, ms_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    wren_d     = 1'b0;
    rden_d     = 1'b0;
    addr_d     = addr_q;
    wdata_d    = 32'd0;
    done_d     = 1'b0;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_WRITE;
          idx_d      = 8'd0;
          wren_d     = 1'b1;
          addr_d     = in_word[63:32];
          wdata_d    = in_word[31:0];
          err_d      = ERR_OK;
          err_addr_d = 32'd0;
        end
      end
      S_WRITE: begin
        idx_d = nxt_idx;
        if (last_word) begin
          if (verify_q) begin
            state_d = S_READ;
            rden_d  = 1'b1;
            addr_d  = nxt_word[63:32];
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          wren_d  = 1'b1;
          addr_d  = nxt_word[63:32];
          wdata_d = nxt_word[31:0];
        end
      end
      S_READ: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        if (i_rule_rdata_valid) begin
          if (i_rule_rdata != cur_word[31:0]) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            err_d      = ERR_CMP;
            err_addr_d = cur_word[63:32];
          end else if (last_word) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            idx_d   = nxt_idx;
            rden_d  = 1'b1;
            addr_d  = nxt_word[63:32];
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          err_d      = ERR_TIMEOUT;
          err_addr_d = cur_word[63:32];
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 8'd0;
      tmo_q      <= '0;
      wren_q     <= 1'b0;
      rden_q     <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= ERR_OK;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      wren_q     <= wren_d;
      rden_q     <= rden_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      layer_q  <= 8'd0;
      verify_q <= 1'b0;
      toff_q   <= '0;
      kv_q     <= '0;
      koff_q   <= '0;
      hs_q     <= '0;
      ms_q     <= '0;
    end else if (accept) begin
      layer_q  <= i_desc_layer;
      verify_q <= i_desc_verify;
      toff_q   <= i_desc_type_offset;
      kv_q     <= i_desc_key_offset_v;
      koff_q   <= i_desc_key_offset;
      hs_q     <= i_desc_head_shift;
      ms_q     <= i_desc_meta_shift;
    end
  end

  assign o_desc_ready = (state_q == S_IDLE);
  assign o_busy       = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_WAIT);
  assign o_rule_wren  = wren_q;
  assign o_rule_rden  = rden_q;
  assign o_rule_addr  = addr_q;
  assign o_rule_wdata = wdata_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_err_addr   = err_addr_q;

endmodule

// File: tb/tb_parser_rule_loader.sv
// Directed bench for parser_rule_loader: write-only, verified, corrupted, silent and late readback, reset abort, held valid.
module tb_parser_rule_loader;

  logic        i_clk;
  logic        i_rst;
  logic        i_desc_valid;
  logic        o_desc_ready;
  logic [7:0]  i_desc_layer;
  logic        i_desc_verify;
  logic [23:0] i_desc_type_offset;
  logic [7:0]  i_desc_key_offset_v;
  logic [47:0] i_desc_key_offset;
  logic [5:0]  i_desc_head_shift;
  logic [5:0]  i_desc_meta_shift;
  logic        o_rule_wren;
  logic        o_rule_rden;
  logic [31:0] o_rule_addr;
  logic [31:0] o_rule_wdata;
  logic        i_rule_rdata_valid;
  logic [31:0] i_rule_rdata;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_err;
  logic [31:0] o_err_addr;

  int n_cmp = 0;
  int n_err = 0;

  logic        resp_on = 1'b1;
  logic        corrupt = 1'b0;
  int          resp_dly = 2;
  int          pend = 0;
  logic [31:0] pend_dat = 32'd0;
  logic [31:0] mem [logic [31:0]];

  parser_rule_loader dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_desc_valid        (i_desc_valid),
    .o_desc_ready        (o_desc_ready),
    .i_desc_layer        (i_desc_layer),
    .i_desc_verify       (i_desc_verify),
    .i_desc_type_offset  (i_desc_type_offset),
    .i_desc_key_offset_v (i_desc_key_offset_v),
    .i_desc_key_offset   (i_desc_key_offset),
    .i_desc_head_shift   (i_desc_head_shift),
    .i_desc_meta_shift   (i_desc_meta_shift),
    .o_rule_wren         (o_rule_wren),
    .o_rule_rden         (o_rule_rden),
    .o_rule_addr         (o_rule_addr),
    .o_rule_wdata        (o_rule_wdata),
    .i_rule_rdata_valid  (i_rule_rdata_valid),
    .i_rule_rdata        (i_rule_rdata),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_err               (o_err),
    .o_err_addr          (o_err_addr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-computed rule words for the test descriptor (type {1,2,3,4}, key0 v=1 off=12, key k>0 v=0 off=k, meta 8).
  function automatic logic [31:0] exp_addr(input int j, input logic [7:0] ly);
    if (j < 4)       return {ly, 4'h2, 12'h000, 8'(j)};
    else if (j < 12) return {ly, 4'h3, 12'h000, 8'(j - 4)};
    else if (j == 12) return {ly, 4'h4, 20'h00000};
    else             return {ly, 4'h5, 20'h00000};
  endfunction

  function automatic logic [31:0] exp_data(input int j, input logic [5:0] hs);
    if (j < 4)        return 32'(j + 1);
    else if (j == 4)  return 32'h0001_000C;
    else if (j < 12)  return 32'(j - 4);
    else if (j == 12) return {26'd0, hs};
    else              return 32'h0000_0008;
  endfunction

  // Readback responder: remembers written words, answers resp_dly cycles after each rden.
  initial begin
    i_rule_rdata_valid = 1'b0;
    i_rule_rdata       = 32'd0;
    forever begin
      @(negedge i_clk);
      i_rule_rdata_valid = 1'b0;
      i_rule_rdata       = 32'd0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          i_rule_rdata_valid = 1'b1;
          i_rule_rdata       = pend_dat;
        end
      end
      if (o_rule_wren) mem[o_rule_addr] = o_rule_wdata;
      if (o_rule_rden && resp_on) begin
        pend     = resp_dly;
        pend_dat = mem.exists(o_rule_addr) ? mem[o_rule_addr] : 32'd0;
        if (corrupt && o_rule_addr == 32'h0230_0003) pend_dat = 32'd0;
      end
    end
  end

  task automatic accept(input logic hold);
    @(negedge i_clk);
    i_desc_valid = 1'b1;
    chk("accept_ready", 32'(o_desc_ready), 32'd1);
    @(posedge i_clk);
    #1;
    if (!hold) i_desc_valid = 1'b0;
  endtask

  task automatic run_write(input logic [7:0] ly, input logic [5:0] hs);
    for (int j = 0; j < 14; j++) begin
      @(negedge i_clk);
      chk($sformatf("wr%0d_wren", j), 32'(o_rule_wren), 32'd1);
      chk($sformatf("wr%0d_addr", j), o_rule_addr, exp_addr(j, ly));
      chk($sformatf("wr%0d_data", j), o_rule_wdata, exp_data(j, hs));
      if (j == 0) chk("wr_busy", 32'(o_busy), 32'd1);
    end
    @(negedge i_clk);
    chk("wr_done", 32'(o_done), 32'd1);
    chk("wr_done_wren", 32'(o_rule_wren), 32'd0);
    chk("wr_err", 32'(o_err), 32'd0);
    chk("wr_done_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic run_verify(input int exp_cyc, input int exp_rd, input logic [1:0] exp_err,
                            input logic [31:0] exp_eaddr);
    int rd_cnt;
    int ovl;
    int done_cyc;
    rd_cnt   = 0;
    ovl      = 0;
    done_cyc = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge i_clk);
      if (o_rule_rden) rd_cnt++;
      if (o_rule_rden && (o_rule_wren || o_rule_wdata != 32'd0)) ovl++;
      if (o_done) begin
        done_cyc = c;
        break;
      end
    end
    chk("vf_done_cycle", 32'(done_cyc), 32'(exp_cyc));
    chk("vf_err", 32'(o_err), 32'(exp_err));
    chk("vf_err_addr", o_err_addr, exp_eaddr);
    repeat (5) begin
      @(negedge i_clk);
      if (o_rule_rden) rd_cnt++;
    end
    chk("vf_rden_count", 32'(rd_cnt), 32'(exp_rd));
    chk("vf_rd_overlap", 32'(ovl), 32'd0);
    chk("vf_err_held", 32'(o_err), 32'(exp_err));
    chk("vf_ready", 32'(o_desc_ready), 32'd1);
  endtask

  initial begin
    int dcnt;
    i_rst               = 1'b1;
    i_desc_valid        = 1'b0;
    i_desc_layer        = 8'd2;
    i_desc_verify       = 1'b0;
    i_desc_type_offset  = {6'd4, 6'd3, 6'd2, 6'd1};
    i_desc_key_offset_v = 8'b0000_0001;
    i_desc_key_offset   = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd12};
    i_desc_head_shift   = 6'd14;
    i_desc_meta_shift   = 6'd8;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", 32'(o_desc_ready), 32'd1);
    chk("rst_wren", 32'(o_rule_wren), 32'd0);
    chk("rst_rden", 32'(o_rule_rden), 32'd0);
    chk("rst_addr", o_rule_addr, 32'd0);
    chk("rst_wdata", o_rule_wdata, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_err_addr", o_err_addr, 32'd0);
    i_rst = 1'b0;

    // Plain write, no verify: done at T+15, ready at T+16
    accept(1'b0);
    run_write(8'd2, 6'd14);
    @(negedge i_clk);
    chk("t1_ready_again", 32'(o_desc_ready), 32'd1);
    chk("t1_done_one_cycle", 32'(o_done), 32'd0);

    // Verify with echo 2 cycles after rden: 14 words x 3 cycles after the writes
    i_desc_verify = 1'b1;
    accept(1'b0);
    run_verify(57, 14, 2'd0, 32'd0);

    // Key3 readback corrupted: abort after the 8th compare
    corrupt = 1'b1;
    accept(1'b0);
    run_verify(39, 8, 2'd1, 32'h0230_0003);
    corrupt = 1'b0;

    // No answer: timeout after 16 wait cycles on word 0
    resp_on = 1'b0;
    accept(1'b0);
    run_verify(32, 1, 2'd2, 32'h0220_0000);

    // Answer on exactly the 16th wait cycle counts as a response
    resp_on  = 1'b1;
    resp_dly = 16;
    accept(1'b0);
    run_verify(253, 14, 2'd0, 32'd0);
    resp_dly = 2;

    // Reset during the fifth write
    i_desc_verify = 1'b0;
    accept(1'b0);
    for (int j = 0; j < 5; j++) begin
      @(negedge i_clk);
      chk($sformatf("rs_wr%0d_addr", j), o_rule_addr, exp_addr(j, 8'd2));
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rs_wren_drop", 32'(o_rule_wren), 32'd0);
    chk("rs_ready", 32'(o_desc_ready), 32'd1);
    chk("rs_busy", 32'(o_busy), 32'd0);
    dcnt = 0;
    repeat (4) begin
      if (o_done) dcnt++;
      @(negedge i_clk);
    end
    chk("rs_no_done", 32'(dcnt), 32'd0);
    accept(1'b0);
    run_write(8'd2, 6'd14);

    // Valid held across two descriptors; fields change while the first is in flight
    accept(1'b1);
    i_desc_layer      = 8'd3;
    i_desc_head_shift = 6'd63;
    run_write(8'd2, 6'd14);
    chk("hv_ready_in_done", 32'(o_desc_ready), 32'd0);
    @(negedge i_clk);
    chk("hv_ready_after_done", 32'(o_desc_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_desc_valid = 1'b0;
    run_write(8'd3, 6'd63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parser_rule_loader.md
Name: parser_rule_loader

Overview:
- Configuration initiator for the pipelined packet parser: drives the parser's rule write/read port (wren/rden/addr/wdata in, rdata_valid/rdata out).
- Accepts one layer-rule descriptor per valid/ready handshake and serialises it into single-word rule writes: type offsets, key offsets, head shift, meta shift.
- Optionally reads every written word back, compares it, and reports done/error to the host-side control logic.

Parameters:
- TYPE_NUM, 4, number of type-offset entries per rule.
- KEY_FILED_NUM, 8, number of key-offset entries per rule.
- TYPE_OFFSET_WIDTH, 6, width of each type offset.
- KEY_OFFSET_WIDTH, 6, width of each key offset (must be ≤16).
- HEAD_SHIFT_WIDTH, 6, width of head shift.
- META_SHIFT_WIDTH, 6, width of meta shift.
- RD_TIMEOUT, 16, cycles to wait for readback data before declaring a timeout (≥2).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_desc_valid  in  1  descriptor valid.
- o_desc_ready  out  1  loader idle, can accept a descriptor.
- i_desc_layer  in  8  target layer ID, placed in addr[31:24].
- i_desc_verify  in  1  1 = read back and compare after writing.
- i_desc_type_offset  in  TYPE_NUM*TYPE_OFFSET_WIDTH  entry i at [i*W+:W].
- i_desc_key_offset_v  in  KEY_FILED_NUM  per-key valid.
- i_desc_key_offset  in  KEY_FILED_NUM*KEY_OFFSET_WIDTH  entry i at [i*W+:W].
- i_desc_head_shift  in  HEAD_SHIFT_WIDTH  head shift.
- i_desc_meta_shift  in  META_SHIFT_WIDTH  meta shift.
- o_rule_wren  out  1  rule write strobe.
- o_rule_rden  out  1  rule read strobe.
- o_rule_addr  out  32  rule address.
- o_rule_wdata  out  32  rule write data.
- i_rule_rdata_valid  in  1  readback data valid.
- i_rule_rdata  in  32  readback data.
- o_busy  out  1  descriptor in progress.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  2  0 = ok, 1 = compare mismatch, 2 = read timeout; held until the next accept.
- o_err_addr  out  32  address of the first failing word; held with o_err.

Behaviour:
- Address format:
  - addr[31:24] = layer; addr[23:20] = info type; addr[19:8] = 0; addr[7:0] = entry ID.
  - Info types: 2 = type offset, 3 = key offset, 4 = head shift, 5 = meta shift.
- Data format:
  - Type offset: wdata[TYPE_OFFSET_WIDTH-1:0].
  - Key offset: wdata[16] = valid, wdata[KEY_OFFSET_WIDTH-1:0] = offset.
  - Shifts: low bits.
  - All unused bits are 0.
- Word order (N = TYPE_NUM + KEY_FILED_NUM + 2 = 14 by default): type 0..TYPE_NUM-1, key 0..KEY_FILED_NUM-1, head shift (ID 0), meta shift (ID 0).
- Reset: state IDLE; o_desc_ready = 1 is the only output not zero; all other outputs 0.
- Handshake:
  - o_desc_ready = (state == IDLE).
  - Accept on i_desc_valid & o_desc_ready; all descriptor fields are registered at accept, and later input changes are ignored.
  - At accept: o_err and o_err_addr clear, o_busy rises next cycle.
- States:
  - IDLE -> WRITE on accept.
  - WRITE: one word per cycle, o_rule_wren = 1 for exactly N consecutive cycles, addr/wdata registered. After word N-1: -> READ if verify, else -> DONE.
  - READ: o_rule_rden = 1 for one cycle with the word's address; o_rule_wdata = 0 -> WAIT.
  - WAIT: on i_rule_rdata_valid, compare i_rule_rdata against the regenerated expected word.
    - Equal: next word -> READ, or after the last word -> DONE.
    - Unequal: o_err = 1, o_err_addr = addr -> DONE (abort).
    - No valid within RD_TIMEOUT cycles (counted from the cycle after rden): o_err = 2 -> DONE.
  - DONE: o_done = 1 for one cycle, o_busy = 0 -> IDLE.
- Latency, accept at cycle T:
  - Writes occupy T+1..T+N.
  - No verify: o_done at T+N+1, o_desc_ready again at T+N+2.
- rdata_valid handling:
  - Ignored outside WAIT.
  - Valid in the same cycle as rden is ignored; the earliest accepted response is the cycle after rden.
  - Valid on the exact timeout cycle counts as a response, not a timeout.
- wren and rden are never asserted together; no strobe is asserted in IDLE or DONE.
- Reset mid-operation returns to IDLE immediately: strobes drop in the same edge, and no partial-rule done pulse is emitted.
- Layer ID is passed through unchecked.

Test Plan:
- Reset, then descriptor layer=2, type_offset={1,2,3,4}, key0 v=1 off=12, other keys v=0, hshift=14, mshift=8, verify=0.
  - 14 wren cycles; first addr 0x0220_0000 data 0x1; key0 addr 0x0230_0000 data 0x0001_000C.
  - Last addr 0x0250_0000 data 0x8; o_done at T+15, o_err = 0.
- Same descriptor with verify=1; responder echoes each word 2 cycles after rden.
  - 14 rden/compare pairs, o_done pulse, o_err = 0.
- Verify with the responder corrupting the key3 word (returns 0).
  - Abort after that compare; o_err = 1, o_err_addr = 0x0230_0003, o_done pulse, no further rden.
- Verify with the responder never answering.
  - o_err = 2 after 16 wait cycles on the first word, o_err_addr = 0x0220_0000.
  - Answer on exactly cycle 16 -> accepted as ok.
- Assert i_rst during write 5.
  - wren = 0 next cycle, o_desc_ready = 1, no o_done.
  - A new descriptor is accepted and fully written.
- Hold i_desc_valid high across two descriptors, changing fields mid-operation.
  - The second is accepted only after DONE; first-rule words are unaffected.
